// File: rtl/valid_flop.sv
// Single-entry valid/ready pipeline register: breaks the valid/data path between stages while
// the ready path stays combinational.
module valid_flop #(
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_up,
  input  logic [width-1:0] data_up,
  input  logic             ready_down,
  output logic             ready_up,
  output logic             valid_down,
  output logic [width-1:0] data_down
);

  logic             valid_q, valid_d;
  logic [width-1:0] data_q, data_d;

  // Accept whenever the held item leaves this cycle or there is none.
  assign ready_up = ready_down | ~valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_up) begin
      valid_d = valid_up;
      // Payload only moves on a real transfer; an emptied stage keeps its stale data.
      if (valid_up) begin
        data_d = data_up;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_down = valid_q;
  assign data_down  = data_q;

endmodule

// File: tb/tb_valid_flop.sv
// Directed bench for valid_flop: reset, fill/stall, drain, streaming and asynchronous reset.
module tb_valid_flop;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_up;
  logic [W-1:0] data_up;
  logic         ready_down;
  logic         ready_up;
  logic         valid_down;
  logic [W-1:0] data_down;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  valid_flop #(
    .width(W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .valid_up  (valid_up),
    .data_up   (data_up),
    .ready_down(ready_down),
    .ready_up  (ready_up),
    .valid_down(valid_down),
    .data_down (data_down)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    valid_up   = 1'b1;
    data_up    = 4'd7;
    ready_down = 1'b0;
    #1;
    check("rst_valid", valid_down, 0);
    check("rst_data", data_down, 0);
    step();
    step();
    check("rst_hold_valid", valid_down, 0);
    check("rst_hold_data", data_down, 0);
    check("rst_ready_up", ready_up, 1);

    // Release between edges: still empty until the next edge.
    valid_up = 1'b0;
    rst      = 1'b0;
    #1;
    check("post_rst_valid", valid_down, 0);

    // Fill and stall.
    valid_up = 1'b1;
    data_up  = 4'd7;
    step();
    check("fill_valid", valid_down, 1);
    check("fill_data", data_down, 7);
    check("fill_ready_up", ready_up, 0);
    data_up = 4'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", data_down, 7);
      check("stall_valid", valid_down, 1);
    end

    // Drain with nothing new.
    valid_up   = 1'b0;
    ready_down = 1'b1;
    #1;
    check("drain_ready_comb", ready_up, 1);
    step();
    check("drain_valid", valid_down, 0);
    check("drain_data_kept", data_down, 7);

    // Second item.
    ready_down = 1'b0;
    valid_up   = 1'b1;
    data_up    = 4'd15;
    step();
    valid_up = 1'b0;
    check("second_valid", valid_down, 1);
    check("second_data", data_down, 15);
    ready_down = 1'b1;
    step();
    check("second_drain_valid", valid_down, 0);

    // Streaming at full rate.
    ready_down = 1'b1;
    valid_up   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      data_up = W'(i);
      step();
      check("stream_valid", valid_down, 1);
      check("stream_data", data_down, i);
      check("stream_ready_up", ready_up, 1);
    end
    valid_up = 1'b0;
    step();
    check("stream_end_valid", valid_down, 0);

    // Asynchronous reset while full.
    ready_down = 1'b0;
    valid_up   = 1'b1;
    data_up    = 4'd9;
    step();
    valid_up = 1'b0;
    check("full_data", data_down, 9);
    check("full_valid", valid_down, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", valid_down, 0);
    check("async_rst_data", data_down, 0);
    rst = 1'b0;

    // First edge after release accepts.
    valid_up = 1'b1;
    data_up  = 4'd5;
    step();
    valid_up = 1'b0;
    check("after_rst_valid", valid_down, 1);
    check("after_rst_data", data_down, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/valid_flop.md
Name: valid_flop

Overview:
- Single-entry pipeline register stage for a valid/ready handshake channel.
- Registers `valid` and `data` from an upstream producer and presents them to a downstream consumer one cycle later.
- Upstream is back-pressured only while the stage holds an unconsumed item.
- Used to break the valid/data timing path between pipeline stages. The ready path stays combinational; this is not a skid buffer.

Parameters:
- width, 4, bit width of the data payload (data_up, data_down); legal range ≥1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous and active-high (clears state immediately on assertion, independent of clk).
- valid_up  input  1  upstream asserts that data_up holds a valid item.
- data_up  input  width  upstream payload.
- ready_down  input  1  downstream is able to accept the item on data_down this cycle.
- ready_up  output  1  stage can accept an upstream item this cycle.
- valid_down  output  1  data_down holds a valid item.
- data_down  output  width  registered payload presented downstream.

Behaviour:
- State: one valid bit (drives valid_down) and one width-bit data register (drives data_down). No other state.
- Reset (rst=1, asynchronous): valid_down=0 and data_down=0 immediately; both hold while rst=1.
  - While in reset, ready_up evaluates to 1 by the formula below, but no transfer is captured.
- ready_up = ready_down OR NOT valid_down. This is purely combinational with no registers in the path.
- Upstream transfer occurs on a rising edge when valid_up=1 and ready_up=1.
- Downstream transfer occurs on a rising edge when valid_down=1 and ready_down=1.
- Rising edge of clk with rst=0:
  - If ready_up=1:
    - valid_down <= valid_up.
    - If valid_up=1, data_down <= data_up.
  - If ready_up=0 (valid_down=1 and ready_down=0, i.e. stall): valid_down and data_down hold unchanged.
- Data register loads only on an upstream transfer. When the stage empties (valid_up=0 while ready_up=1), data_down keeps its last value, but valid_down=0 marks it invalid.
- Latency: an accepted item appears on valid_down/data_down exactly one cycle after the accepting edge.
- Throughput: one item per cycle while ready_down is held at 1.
- Simultaneous consume + fill (valid_down=1, ready_down=1, valid_up=1): the old item is consumed and the new item is loaded on the same edge, so valid_down stays 1.
- Consume with no new input (valid_down=1, ready_down=1, valid_up=0): valid_down falls to 0 on that edge.
- Stability: while valid_down=1 and ready_down=0, data_down must not change.
- Upstream protocol: the producer must hold valid_up/data_up stable until accepted. The stage does not check for protocol violations.
- No combinational path from valid_up or data_up to any output.
- Reset mid-operation: any held item is discarded immediately (valid_down=0, data_down=0). After release, the stage is empty and accepts on the first edge.

Test Plan:
- Reset: assert rst=1 with valid_up=1, data_up=7 -> valid_down=0, data_down=0, ready_up=1, and nothing captured while rst=1; deassert rst -> still empty until the next edge.
- Fill and stall:
  - Stimulus: ready_down=0, one-cycle pulse valid_up=1 with data_up=7.
  - Response: next edge gives valid_down=1, data_down=7, ready_up=0.
  - Then change data_up to 3 with valid_up=1: data_down stays 7 for several cycles.
- Drain: from the held state (7), raise ready_down=1 for one cycle with valid_up=0 -> ready_up=1 immediately (combinationally), valid_down=0 after the edge, and data_down stays 7.
- Second item: data_up=15, valid_up=1 for one cycle with ready_down=0 -> valid_down=1, data_down=15; then ready_down=1 -> valid_down=0 after one edge.
- Streaming: ready_down=1 and valid_up=1 with data_up=1,2,3,4 on consecutive edges -> data_down=1,2,3,4 one cycle later each, with valid_down continuously 1 and ready_up continuously 1.
- Asynchronous reset while full (valid_down=1, data_down=9, ready_down=0): assert rst between clock edges -> valid_down=0 and data_down=0 before the next rising edge.
